// File: rtl/keypad_seq_lock_pkg.sv
// Shared types and constants for the keypad sequence lock.
package keypad_seq_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_STRIKE  = 2'd2,
        ST_DEFUSED = 2'd3
    } state_e;

    // Keypad code meaning "no key pressed".
    localparam int NEUTRAL_CODE = 0;

    // Strike counter width and saturation value.
    localparam int          STRIKE_CNT_W   = 4;
    localparam logic [3:0]  STRIKE_CNT_MAX = 4'd15;

    // Default sequences: A=2,2,6,4  B=1,3,5,7  C=4,4,1,2  D=8,6,3,3.
    // Versions and positions beyond four wrap onto this table.
    function automatic logic [7:0] seq_code(input logic [1:0] ver, input logic [1:0] idx);
        logic [7:0] code;
        case ({ver, idx})
            4'h0: code = 8'd2;
            4'h1: code = 8'd2;
            4'h2: code = 8'd6;
            4'h3: code = 8'd4;
            4'h4: code = 8'd1;
            4'h5: code = 8'd3;
            4'h6: code = 8'd5;
            4'h7: code = 8'd7;
            4'h8: code = 8'd4;
            4'h9: code = 8'd4;
            4'hA: code = 8'd1;
            4'hB: code = 8'd2;
            4'hC: code = 8'd8;
            4'hD: code = 8'd6;
            4'hE: code = 8'd3;
            default: code = 8'd3;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_seq_lock_if.sv
// Control/status bundle between the bomb controller and the keypad puzzle.
interface keypad_seq_lock_if #(
    parameter int KEY_W        = 7,
    parameter int SEQ_LEN      = 4,
    parameter int NUM_VERSIONS = 4
);
    localparam int VER_W = (NUM_VERSIONS > 1) ? $clog2(NUM_VERSIONS) : 1;
    localparam int IDX_W = $clog2(SEQ_LEN + 1);

    logic             enable;
    logic [VER_W-1:0] version;
    logic [KEY_W-1:0] keypad;
    logic             strike;
    logic             module_defused;
    logic [IDX_W-1:0] progress;
    logic [3:0]       strike_count;
    logic [VER_W-1:0] active_version;

    modport master (
        output enable, version, keypad,
        input  strike, module_defused, progress, strike_count, active_version
    );

    modport slave (
        input  enable, version, keypad,
        output strike, module_defused, progress, strike_count, active_version
    );
endinterface

// File: rtl/keypad_seq_lock_debounce.sv
// Keypad debouncer: accepts a code after STABLE_CYCLES identical samples and
// emits a one-cycle press event on a neutral -> key transition.
import keypad_seq_lock_pkg::*;

module keypad_seq_lock_debounce #(
    parameter int KEY_W         = 7,
    parameter int STABLE_CYCLES = 270000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             rel_clr,
    input  logic [KEY_W-1:0] keypad,
    output logic [KEY_W-1:0] stable_code,
    output logic             press_evt
);
    localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [KEY_W-1:0] NEUTRAL = KEY_W'(NEUTRAL_CODE);

    logic [KEY_W-1:0] samp_q, samp_d, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, run;
    logic             rel_q, rel_d, evt_q, evt_d, accept;

    // Run length of the current code, acceptance, and release/press bookkeeping.
    always_comb begin
        samp_d   = samp_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rel_d    = rel_q;
        evt_d    = evt_q;
        run      = (keypad == samp_q) ? ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1))
                                      : CNT_W'(1);
        accept   = (run == CNT_MAX);
        if (enable) begin
            samp_d = keypad;
            cnt_d  = run;
            evt_d  = accept && (keypad != NEUTRAL) && (stable_q == NEUTRAL) && rel_q;
            if (accept)
                stable_d = keypad;
            // Arming wins so a key held across arm must be released first.
            if (rel_clr || evt_d)
                rel_d = 1'b0;
            else if (accept && keypad == NEUTRAL)
                rel_d = 1'b1;
        end
    end

    // Debounce state registers; everything holds while disabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            samp_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            rel_q    <= 1'b0;
            evt_q    <= 1'b0;
        end else begin
            samp_q   <= samp_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rel_q    <= rel_d;
            evt_q    <= evt_d;
        end
    end

    assign stable_code = stable_q;
    // A pending event survives a freeze and is consumed on resume.
    assign press_evt   = evt_q & enable;

endmodule

// File: rtl/keypad_seq_lock.sv
// Keypad sequence-entry puzzle: checks debounced presses against the stored
// sequence chosen at arm time, pulses strike on errors, latches defuse.
import keypad_seq_lock_pkg::*;

module keypad_seq_lock #(
    parameter int KEY_W         = 7,
    parameter int SEQ_LEN       = 4,
    parameter int NUM_VERSIONS  = 4,
    parameter int STABLE_CYCLES = 270000
) (
    input  logic                clock,
    input  logic                reset,
    keypad_seq_lock_if.slave    bus
);
    localparam int VER_W = (NUM_VERSIONS > 1) ? $clog2(NUM_VERSIONS) : 1;
    localparam int IDX_W = $clog2(SEQ_LEN + 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] progress_q, progress_d;
    logic [3:0]       strike_count_q, strike_count_d;
    logic [VER_W-1:0] active_version_q, active_version_d;
    logic [KEY_W-1:0] stable_code, exp_code;
    logic             press_evt;

    keypad_seq_lock_debounce #(
        .KEY_W         (KEY_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .clock       (clock),
        .reset       (reset),
        .enable      (bus.enable),
        .rel_clr     (state_q == ST_IDLE),
        .keypad      (bus.keypad),
        .stable_code (stable_code),
        .press_evt   (press_evt)
    );

    // Sequence ROM lookup for the next expected press.
    assign exp_code = KEY_W'(seq_code(2'(active_version_q), 2'(progress_q)));

    // Next-state logic: arm, compare presses, strike, defuse.
    always_comb begin
        state_d          = state_q;
        progress_d       = progress_q;
        strike_count_d   = strike_count_q;
        active_version_d = active_version_q;
        if (bus.enable) begin
            case (state_q)
                ST_IDLE: begin
                    state_d          = ST_ARMED;
                    active_version_d = bus.version;
                end
                ST_ARMED: begin
                    if (press_evt) begin
                        if (stable_code == exp_code) begin
                            progress_d = progress_q + IDX_W'(1);
                            if (progress_q == IDX_W'(SEQ_LEN - 1))
                                state_d = ST_DEFUSED;
                        end else begin
                            state_d    = ST_STRIKE;
                            progress_d = '0;
                            if (strike_count_q != STRIKE_CNT_MAX)
                                strike_count_d = strike_count_q + 4'd1;
                        end
                    end
                end
                ST_STRIKE:  state_d = ST_ARMED;
                ST_DEFUSED: state_d = ST_DEFUSED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // State and status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            progress_q       <= '0;
            strike_count_q   <= '0;
            active_version_q <= '0;
        end else begin
            state_q          <= state_d;
            progress_q       <= progress_d;
            strike_count_q   <= strike_count_d;
            active_version_q <= active_version_d;
        end
    end

    assign bus.strike         = bus.enable && (state_q == ST_STRIKE);
    assign bus.module_defused = (state_q == ST_DEFUSED);
    assign bus.progress       = progress_q;
    assign bus.strike_count   = strike_count_q;
    assign bus.active_version = active_version_q;

endmodule

// File: tb/tb_keypad_seq_lock.sv
// Directed bench for keypad_seq_lock with STABLE_CYCLES=4, SEQ_LEN=4.
module tb_keypad_seq_lock;
    localparam int KEY_W = 7, SEQ_LEN = 4, NUM_VERSIONS = 4, STABLE_CYCLES = 4;
    localparam int VER_W = 2, IDX_W = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    keypad_seq_lock_if #(.KEY_W(KEY_W), .SEQ_LEN(SEQ_LEN), .NUM_VERSIONS(NUM_VERSIONS)) bus ();

    keypad_seq_lock #(
        .KEY_W(KEY_W), .SEQ_LEN(SEQ_LEN), .NUM_VERSIONS(NUM_VERSIONS), .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // One record = hold these inputs for n edges, then expect these outputs;
    // strk is the number of edges after which strike was seen high.
    typedef struct {
        logic rst;
        logic en;
        int   ver;
        int   key;
        int   n;
        int   prog;
        logic def;
        int   cnt;
        int   aver;
        int   strk;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic rst, input logic en, input int ver, input int key, input int n,
                       input int prog, input logic def, input int cnt, input int aver, input int strk);
        vec_t v;
        v.rst = rst; v.en = en; v.ver = ver; v.key = key; v.n = n;
        v.prog = prog; v.def = def; v.cnt = cnt; v.aver = aver; v.strk = strk;
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // 1: sequence A, presses and releases, extra press after defuse ignored
        add(1,1,0,0,2, 0,0,0,0,0);
        add(0,1,0,0,5, 0,0,0,0,0);
        add(0,1,0,2,5, 1,0,0,0,0);
        add(0,1,0,0,5, 1,0,0,0,0);
        add(0,1,0,2,5, 2,0,0,0,0);
        add(0,1,0,0,5, 2,0,0,0,0);
        add(0,1,0,6,5, 3,0,0,0,0);
        add(0,1,0,0,5, 3,0,0,0,0);
        add(0,1,0,4,4, 3,0,0,0,0);
        add(0,1,0,4,1, 4,1,0,0,0);
        add(0,1,0,0,5, 4,1,0,0,0);
        add(0,1,0,7,5, 4,1,0,0,0);
        // 2: version B (1,3,5,7): two correct, one wrong, then full sequence
        add(1,1,1,0,2, 0,0,0,0,0);
        add(0,1,1,0,5, 0,0,0,1,0);
        add(0,1,1,1,5, 1,0,0,1,0);
        add(0,1,1,0,5, 1,0,0,1,0);
        add(0,1,1,3,5, 2,0,0,1,0);
        add(0,1,1,0,5, 2,0,0,1,0);
        add(0,1,1,9,4, 2,0,0,1,0);
        add(0,1,1,9,1, 0,0,1,1,1);
        add(0,1,1,0,5, 0,0,1,1,0);
        add(0,1,1,1,5, 1,0,1,1,0);
        add(0,1,1,0,5, 1,0,1,1,0);
        add(0,1,1,3,5, 2,0,1,1,0);
        add(0,1,1,0,5, 2,0,1,1,0);
        add(0,1,1,5,5, 3,0,1,1,0);
        add(0,1,1,0,5, 3,0,1,1,0);
        add(0,1,1,7,5, 4,1,1,1,0);
        // 3: bounce every 2 cycles for 20 cycles, then stable; version change ignored
        add(1,1,0,0,2, 0,0,0,0,0);
        add(0,1,0,0,5, 0,0,0,0,0);
        for (int k = 0; k < 5; k++) begin
            add(0,1,3,2,2, 0,0,0,0,0);
            add(0,1,3,0,2, 0,0,0,0,0);
        end
        add(0,1,3,2,5,  1,0,0,0,0);
        add(0,1,3,2,10, 1,0,0,0,0);
        // 4: key held across arm, slide to another key, then release and press
        add(1,1,0,2,2, 0,0,0,0,0);
        add(0,1,0,2,8, 0,0,0,0,0);
        add(0,1,0,6,8, 0,0,0,0,0);
        add(0,1,0,0,3, 0,0,0,0,0);
        add(0,1,0,0,2, 0,0,0,0,0);
        add(0,1,0,2,5, 1,0,0,0,0);
        // 5: freeze mid-debounce for 50 cycles with a different key on the pins
        add(1,1,0,0,2,  0,0,0,0,0);
        add(0,1,0,0,5,  0,0,0,0,0);
        add(0,1,0,2,2,  0,0,0,0,0);
        add(0,0,2,5,50, 0,0,0,0,0);
        add(0,1,0,2,2,  0,0,0,0,0);
        add(0,1,0,2,1,  1,0,0,0,0);
        // 6: 16 wrong presses saturate the counter, then reset during STRIKE
        add(1,1,0,0,2, 0,0,0,0,0);
        add(0,1,0,0,5, 0,0,0,0,0);
        for (int k = 0; k < 16; k++) begin
            add(0,1,0,7,5, 0,0,(k + 1 > 15) ? 15 : k + 1,0,1);
            add(0,1,0,0,5, 0,0,(k + 1 > 15) ? 15 : k + 1,0,0);
        end
        add(0,1,0,7,5, 0,0,15,0,1);
        add(1,1,0,0,1, 0,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            int seen;
            reset       = vecs[i].rst;
            bus.enable  = vecs[i].en;
            bus.version = VER_W'(vecs[i].ver);
            bus.keypad  = KEY_W'(vecs[i].key);
            seen = 0;
            for (int c = 0; c < vecs[i].n; c++) begin
                @(posedge clock);
                #1;
                if (bus.strike === 1'b1) seen++;
            end
            n_vec++;
            if (bus.progress !== IDX_W'(vecs[i].prog) || bus.module_defused !== vecs[i].def ||
                bus.strike_count !== 4'(vecs[i].cnt) || bus.active_version !== VER_W'(vecs[i].aver) ||
                seen != vecs[i].strk) begin
                n_err++;
                $display("FAIL vec%0d: progress %0d exp %0d, defused %0b exp %0b, strike_count %0d exp %0d, active_version %0d exp %0d, strike cycles %0d exp %0d",
                         i, bus.progress, vecs[i].prog, bus.module_defused, vecs[i].def,
                         bus.strike_count, vecs[i].cnt, bus.active_version, vecs[i].aver,
                         seen, vecs[i].strk);
            end
        end

        // Cycle-exact latency: progress changes on the 5th edge of a held key.
        reset = 1'b0; bus.enable = 1'b1; bus.version = '0; bus.keypad = '0;
        step(5);
        bus.keypad = 7'd2;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk($sformatf("latency progress edge %0d", k), int'(bus.progress), (k >= 5) ? 1 : 0);
        end

        // Reset coinciding with a pending wrong press: reset wins, no strike.
        bus.keypad = '0;
        step(5);
        bus.keypad = 7'd7;
        step(4);
        chk("pending evt strike", int'(bus.strike), 0);
        reset = 1'b1;
        step(1);
        chk("reset vs evt strike", int'(bus.strike), 0);
        chk("reset vs evt count", int'(bus.strike_count), 0);
        chk("reset vs evt progress", int'(bus.progress), 0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            chk("held key after reset strike", int'(bus.strike), 0);
        end
        chk("held key after reset count", int'(bus.strike_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
